game_ctrl: RTL and testbench

Frame-rate game-state engine for the wall-dodging game. It owns the player block position, the scrolling wall, the gap geometry, the score and the play/dead state machine. It drives blkpos_x, blkpos_y, wall_x, gap_y and gap_size into the pixel draw stage, and consumes that stage's combinational `lose` collision flag. All motion updates once per video frame on `frame_tick`.

---
 rtl/game_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_game_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Frame-rate game-state engine: block physics, scrolling wall, gap geometry,
// score and the IDLE/PLAY/DEAD state machine, all updated on frame_tick.
module game_ctrl #(
  parameter int       BLK_X      = 200,
  parameter int       START_Y    = 428,
  parameter int       GRAVITY    = 1,
  parameter int       FLAP_VEL   = -8,
  parameter int       MAX_FALL   = 12,
  parameter int       WALL_SPEED = 4,
  parameter int       GAP_INIT   = 200,
  parameter int       GAP_MIN    = 96,
  parameter int       GAP_STEP   = 4,
  parameter bit [9:0] LFSR_SEED  = 10'h2A5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        btn_flap,
  input  logic        lose,
  output logic [10:0] blkpos_x,
  output logic [10:0] blkpos_y,
  output logic [10:0] wall_x,
  output logic [10:0] gap_y,
  output logic [10:0] gap_size,
  output logic [7:0]  score,
  output logic [1:0]  state
);

  localparam logic [10:0] WALL_HOME = 11'd1418;
  localparam logic [10:0] Y_CEIL    = 11'd10;
  localparam logic [10:0] Y_FLOOR   = 11'd856;
  localparam logic [10:0] GAP_BASE  = 11'd20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] blkpos_y_d, wall_x_d, gap_y_d, gap_size_d;
  logic [7:0]  score_d;
  logic signed [5:0] vel_q, vel_d, vel_nxt;
  logic signed [6:0] vel_inc;
  logic signed [11:0] y_new;
  logic        pend_q, pend_d, flap_now;
  logic        sync1, sync2, sync3, flap_edge;
  logic [9:0]  lfsr;

  // Button synchronizer plus registered rising-edge detect (3 clk latency).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      flap_edge <= 1'b0;
    end else begin
      sync1     <= btn_flap;
      sync2     <= sync1;
      sync3     <= sync2;
      flap_edge <= sync2 & ~sync3;
    end
  end

  // Free-running x^10+x^7+1 Fibonacci LFSR; gap placement depends on player timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
  end

  // A flap edge landing on the tick cycle itself is honoured immediately.
  always_comb begin
    flap_now = pend_q | flap_edge;
    vel_inc  = {vel_q[5], vel_q} + 7'(GRAVITY);
    if (flap_now)
      vel_nxt = 6'(FLAP_VEL);
    else if (vel_inc > $signed(7'(MAX_FALL)))
      vel_nxt = 6'(MAX_FALL);
    else
      vel_nxt = vel_inc[5:0];
    y_new = $signed({1'b0, blkpos_y}) + $signed({{6{vel_nxt[5]}}, vel_nxt});
  end

  always_comb begin
    state_d    = state_q;
    blkpos_y_d = blkpos_y;
    vel_d      = vel_q;
    wall_x_d   = wall_x;
    gap_y_d    = gap_y;
    gap_size_d = gap_size;
    score_d    = score;
    pend_d     = pend_q;

    case (state_q)
      IDLE: begin
        blkpos_y_d = 11'(START_Y);
        vel_d      = '0;
        wall_x_d   = WALL_HOME;
        gap_size_d = 11'(GAP_INIT);
        pend_d     = 1'b0;
        if (flap_edge) begin
          state_d = PLAY;
          score_d = '0;
        end
      end

      PLAY: begin
        if (lose) begin
          state_d = DEAD;
          pend_d  = 1'b0;
        end else begin
          if (flap_edge) pend_d = 1'b1;
          if (frame_tick) begin
            vel_d  = vel_nxt;
            pend_d = 1'b0;
            if (y_new < 12'sd10) begin
              blkpos_y_d = Y_CEIL;
            end else if (y_new >= 12'sd856) begin
              blkpos_y_d = Y_FLOOR;
              state_d    = DEAD;
            end else begin
              blkpos_y_d = y_new[10:0];
            end

            if (wall_x < 11'(10 + WALL_SPEED)) begin
              wall_x_d = WALL_HOME;
              gap_y_d  = GAP_BASE + {2'b00, lfsr[8:0]};
              if (score != 8'hFF) score_d = score + 8'd1;
              if (gap_size >= 11'(GAP_MIN + GAP_STEP))
                gap_size_d = gap_size - 11'(GAP_STEP);
              else
                gap_size_d = 11'(GAP_MIN);
            end else begin
              wall_x_d = wall_x - 11'(WALL_SPEED);
            end
          end
        end
      end

      DEAD: begin
        pend_d = 1'b0;
        if (flap_edge) begin
          state_d    = IDLE;
          blkpos_y_d = 11'(START_Y);
          vel_d      = '0;
          wall_x_d   = WALL_HOME;
          gap_size_d = 11'(GAP_INIT);
        end
      end

      default: begin
        state_d = IDLE;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      blkpos_x <= 11'(BLK_X);
      blkpos_y <= 11'(START_Y);
      vel_q    <= '0;
      wall_x   <= WALL_HOME;
      gap_y    <= GAP_BASE;
      gap_size <= 11'(GAP_INIT);
      score    <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      blkpos_x <= 11'(BLK_X);
      blkpos_y <= blkpos_y_d;
      vel_q    <= vel_d;
      wall_x   <= wall_x_d;
      gap_y    <= gap_y_d;
      gap_size <= gap_size_d;
      score    <= score_d;
      pend_q   <= pend_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: start, gravity, flap, floor death, wall wrap,
// gap shrink saturation, collision priority and asynchronous reset.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        btn_flap = 1'b0;
  logic        lose = 1'b0;
  logic [10:0] blkpos_x, blkpos_y, wall_x, gap_y, gap_size;
  logic [7:0]  score;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  game_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_flap   (btn_flap),
    .lose       (lose),
    .blkpos_x   (blkpos_x),
    .blkpos_y   (blkpos_y),
    .wall_x     (wall_x),
    .gap_y      (gap_y),
    .gap_size   (gap_size),
    .score      (score),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_flap = 1'b0;
    frame_tick = 1'b0;
    lose = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic flap();
    @(posedge clk); #1 btn_flap = 1'b1;
    repeat (4) @(posedge clk);
    #1 btn_flap = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_state", state, 0);
    check("rst_blkpos_x", blkpos_x, 200);
    check("rst_blkpos_y", blkpos_y, 428);
    check("rst_wall_x", wall_x, 1418);
    check("rst_gap_y", gap_y, 20);
    check("rst_gap_size", gap_size, 200);
    check("rst_score", score, 0);

    // Start within 4 clk of the button
    @(posedge clk); #1 btn_flap = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (state == 2'd1) break;
    end
    check("start_state", state, 1);
    repeat (4) @(posedge clk);
    #1 btn_flap = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // frame_tick in IDLE would have moved nothing; now gravity
    tick();
    check("grav_t1_y", blkpos_y, 429);
    check("grav_t1_wall", wall_x, 1414);
    tick(); tick();
    check("grav_t3_y", blkpos_y, 434);

    // Flap from vel=3, y=434
    flap();
    check("flap_no_tick_y", blkpos_y, 434);
    tick();
    check("flap_t1_y", blkpos_y, 426);
    tick();
    check("flap_t2_y", blkpos_y, 419);

    // Floor death
    do_reset();
    flap();
    check("floor_start", state, 1);
    for (int i = 1; i <= 42; i++) begin
      tick();
      if (i == 12) check("floor_t12_y", blkpos_y, 506);
      if (i == 41) check("floor_t41_y", blkpos_y, 854);
    end
    check("floor_t42_y", blkpos_y, 856);
    check("floor_t42_state", state, 2);
    tick();
    check("dead_tick_y", blkpos_y, 856);
    check("dead_tick_wall", wall_x, 1418 - 4 * 42);

    // Wall wrap, score, gap shrink to floor, ceiling clamp
    do_reset();
    flap();
    for (int i = 1; i <= 9532; i++) begin
      if ((i - 1) % 8 == 0) flap();
      tick();
      if (i == 352) check("wall_t352", wall_x, 10);
      if (i == 353) begin
        check("wrap_wall", wall_x, 1418);
        check("wrap_score", score, 1);
        check("wrap_gap_size", gap_size, 196);
        check("wrap_gap_y_range", (gap_y >= 20 && gap_y <= 531), 1);
      end
      if (i == 9178) begin
        check("wrap26_score", score, 26);
        check("wrap26_gap_size", gap_size, 96);
      end
    end
    check("wrap27_score", score, 27);
    check("gap_size_floor", gap_size, 96);
    check("wall_after_wrap", wall_x, 1414);
    check("ceiling_y", blkpos_y, 10);
    check("airborne_state", state, 1);

    // Collision on a tick cycle: lose wins, nothing moves
    @(posedge clk); #1 lose = 1'b1; frame_tick = 1'b1;
    @(posedge clk); #1 lose = 1'b0; frame_tick = 1'b0;
    check("coll_state", state, 2);
    check("coll_y", blkpos_y, 10);
    check("coll_wall", wall_x, 1414);
    tick();
    check("coll_dead_tick_wall", wall_x, 1414);
    flap();
    check("restart_state", state, 0);
    check("restart_y", blkpos_y, 428);
    check("restart_wall", wall_x, 1418);
    check("restart_gap_size", gap_size, 200);
    check("restart_score_kept", score, 27);

    // Async reset between clock edges mid-PLAY
    flap();
    tick(); tick(); tick();
    check("pre_reset_y", blkpos_y, 434);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("async_state", state, 0);
    check("async_y", blkpos_y, 428);
    check("async_wall", wall_x, 1418);
    check("async_gap_y", gap_y, 20);
    check("async_gap_size", gap_size, 200);
    check("async_score", score, 0);
    check("async_lfsr", dut.lfsr, 10'h2A5);
    #10 rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
